lsu_align_ctrl: RTL
===================

Name: lsu_align_ctrl

Overview:
Load/store alignment controller sitting directly upstream of the word-addressed data memory. Accepts byte/half/word load and store requests from the MEM stage and performs byte-lane merging and sign/zero extension. Subword stores use read-modify-write. Word-crossing (misaligned) accesses are split into two sequential word accesses, with a stall presented to the pipeline. Drives the data memory's clk-synchronous write port and combinational read port.

Parameters:
ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses into two cycles; 0 = reject them with resp_err
ADDR_W, 32, byte address width; word address wraps modulo 2^ADDR_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high when a request can be accepted (IDLE only)
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle pulse; access complete
resp_data  out  32  load result; 0 for stores and errors
resp_err  out  1  qualifies resp_valid: misaligned (when ALLOW_MISALIGNED=0) or illegal size
mem_addr  out  ADDR_W  word-aligned address to data memory, low 2 bits always 0
mem_read  out  1  read enable to data memory
mem_write  out  1  write enable to data memory
mem_wdata  out  32  merged write word
mem_rdata  in  32  combinational read word from data memory

Behaviour:
- Reset (async): state=IDLE; resp_valid=0; resp_data=0; resp_err=0; captured-request and low-word registers cleared. mem_read, mem_write, mem_wdata and mem_addr are combinational from state and are 0 while in IDLE with no request.
- States: IDLE, SECOND.
- Accept occurs when req_valid && req_ready. req_ready = (state==IDLE).
- Offset o = req_addr[1:0]. Access crosses a word boundary iff (size==01 && o==3) or (size==10 && o!=0). Byte accesses never cross.
- IDLE, accept, illegal size or (crossing && !ALLOW_MISALIGNED): no memory access (mem_read=mem_write=0). Next edge: resp_valid=1, resp_err=1, resp_data=0.
- IDLE, accept, non-crossing: same cycle mem_addr={addr[ADDR_W-1:2],00}, mem_read=1.
  - Store: mem_write=1, mem_wdata=(mem_rdata & ~mask) | ((wdata << 8*o) & mask), where mask = byte lanes o..o+n-1.
  - Next edge: resp_valid=1 with resp_data = extracted/extended load value (0 for stores). Latency: resp one cycle after accept.
- IDLE, accept, crossing, ALLOW_MISALIGNED=1:
  - Cycle T: low word accessed as above. For a store, only lanes o..3 are merged and written.
  - Latch the request and low word (for loads). Next state = SECOND.
- SECOND (cycle T+1): mem_addr = low word address + 4, wrapping 0xFFFFFFFC to 0x00000000. mem_read=1.
  - Store: remaining lanes 0..(o+n-5) are merged with mem_rdata and written, mem_write=1.
  - Load: result byte i = low byte o+i if o+i<4, else mem_rdata byte o+i-4.
  - Next edge: state=IDLE, resp_valid=1. Response appears two cycles after accept.
- Little-endian byte order throughout.
- Load extension: byte/half sign-extended unless req_unsigned. Word loads are unaffected.
- resp_valid is a single-cycle pulse. A new request may be accepted in the same cycle as the previous response (back-to-back).
- req_* inputs are ignored while in SECOND. The pipeline must hold the request until req_ready.
- Reset asserted in SECOND: returns to IDLE immediately and mem_write drops asynchronously. A low-word store already written is not rolled back. No response is issued for the aborted access.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 -> word[0x10]=0xDEADBEEF; resp_data=0xDEADBEEF, resp_valid one cycle after accept, req_ready never low.
- word[0x10]=0x11223344; sb 0xAA @0x13 -> word=0xAA223344; lb @0x13 -> 0xFFFFFFAA; lbu @0x13 -> 0x000000AA; lh @0x12 -> 0xFFFFAA22.
- word[0x0C]=0x44332211, word[0x10]=0x88776655; lw @0x0E -> req_ready low one cycle, mem_addr 0x0C then 0x10, resp_data=0x66554433 two cycles after accept.
- sh 0xBEEF @0x07 over zeroed memory -> word[0x04]=0xEF000000, word[0x08]=0x000000BE; lw @0xFFFFFFFE -> second access mem_addr=0x00000000.
- ALLOW_MISALIGNED=0: lw @0x02, and req_size=11 @0x00 -> mem_write/mem_read stay 0; resp_valid=1, resp_err=1, resp_data=0.
- Misaligned sw 0xCAFEF00D @0x21, rst pulsed during SECOND -> word[0x20] lanes 1..3 updated, word[0x24] unchanged, resp_valid=0, next request accepted normally.

Source files
------------

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller: byte-lane merge, sign/zero extension and
// two-cycle splitting of word-crossing accesses in front of a word-addressed memory.
module lsu_align_ctrl #(
    parameter int unsigned ALLOW_MISALIGNED = 1,
    parameter int unsigned ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [0:0] {StIdle, StSecond} state_e;

    localparam logic AllowSplit = (ALLOW_MISALIGNED != 0);

    state_e            state_q, state_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic              rq_write_q, rq_write_d;
    logic [1:0]        rq_size_q, rq_size_d;
    logic              rq_unsigned_q, rq_unsigned_d;
    logic [ADDR_W-1:0] rq_addr_q, rq_addr_d;
    logic [31:0]       rq_wdata_q, rq_wdata_d;
    logic [31:0]       low_q, low_d;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic uns);
        case (size)
            2'b00:   return uns ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            2'b01:   return uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // Active access: live request in IDLE, captured request in SECOND.
    logic              second;
    logic              cur_write;
    logic [1:0]        cur_size;
    logic              cur_uns;
    logic [1:0]        cur_off;
    logic [31:0]       cur_wdata;
    logic [3:0]        size_mask;
    logic [7:0]        lane_mask8;
    logic [63:0]       sdata64;
    logic [63:0]       raw64;
    logic [63:0]       shifted64;
    logic [3:0]        lanes;
    logic [31:0]       sdata;
    logic [31:0]       merged;
    logic [31:0]       load_val;
    logic              crossing;
    logic              reject;

    always_comb begin
        second    = (state_q == StSecond);
        cur_write = second ? rq_write_q : req_write;
        cur_size  = second ? rq_size_q : req_size;
        cur_uns   = second ? rq_unsigned_q : req_unsigned;
        cur_off   = second ? rq_addr_q[1:0] : req_addr[1:0];
        cur_wdata = second ? rq_wdata_q : req_wdata;

        case (cur_size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase

        // Upper halves of the 64-bit views hold the lanes spilling into the next word.
        lane_mask8 = {4'b0000, size_mask} << cur_off;
        sdata64    = {32'd0, cur_wdata} << {cur_off, 3'b000};
        lanes      = second ? lane_mask8[7:4] : lane_mask8[3:0];
        sdata      = second ? sdata64[63:32] : sdata64[31:0];

        merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) merged[8*i +: 8] = sdata[8*i +: 8];
        end

        raw64     = second ? {mem_rdata, low_q} : {32'd0, mem_rdata};
        shifted64 = raw64 >> {cur_off, 3'b000};
        load_val  = extend(shifted64[31:0], cur_size, cur_uns);

        crossing = (req_size == 2'b01 && req_addr[1:0] == 2'd3) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'd0);
        reject   = (req_size == 2'b11) || (crossing && !AllowSplit);
    end

    always_comb begin
        state_d       = state_q;
        resp_valid_d  = 1'b0;
        resp_data_d   = 32'd0;
        resp_err_d    = 1'b0;
        rq_write_d    = rq_write_q;
        rq_size_d     = rq_size_q;
        rq_unsigned_d = rq_unsigned_q;
        rq_addr_d     = rq_addr_q;
        rq_wdata_d    = rq_wdata_q;
        low_d         = low_q;
        req_ready     = (state_q == StIdle);
        mem_addr      = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_wdata     = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (reject) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_read  = 1'b1;
                        mem_write = req_write;
                        mem_wdata = req_write ? merged : 32'd0;
                        if (crossing) begin
                            state_d       = StSecond;
                            rq_write_d    = req_write;
                            rq_size_d     = req_size;
                            rq_unsigned_d = req_unsigned;
                            rq_addr_d     = req_addr;
                            rq_wdata_d    = req_wdata;
                            low_d         = mem_rdata;
                        end else begin
                            resp_valid_d = 1'b1;
                            resp_data_d  = req_write ? 32'd0 : load_val;
                        end
                    end
                end
            end
            StSecond: begin
                mem_addr     = {rq_addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1}, 2'b00};
                mem_read     = 1'b1;
                mem_write    = rq_write_q;
                mem_wdata    = rq_write_q ? merged : 32'd0;
                state_d      = StIdle;
                resp_valid_d = 1'b1;
                resp_data_d  = rq_write_q ? 32'd0 : load_val;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= 32'd0;
            resp_err_q    <= 1'b0;
            rq_write_q    <= 1'b0;
            rq_size_q     <= 2'b00;
            rq_unsigned_q <= 1'b0;
            rq_addr_q     <= '0;
            rq_wdata_q    <= 32'd0;
            low_q         <= 32'd0;
        end else begin
            state_q       <= state_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            resp_err_q    <= resp_err_d;
            rq_write_q    <= rq_write_d;
            rq_size_q     <= rq_size_d;
            rq_unsigned_q <= rq_unsigned_d;
            rq_addr_q     <= rq_addr_d;
            rq_wdata_q    <= rq_wdata_d;
            low_q         <= low_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule
